boot_loader_ctrl: RTL and testbench
===================================

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64: instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default 6: instruction memory word-address width, clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, 8: byte from the serial receiver.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: loader accepts a byte; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-008 SHALL have port boot_req, input, 1: request a reload of the program.
REQ-009 SHALL have port imem_we, output, 1: instruction memory write strobe.
REQ-010 SHALL have port imem_waddr, output, AW: word address of the write.
REQ-011 SHALL have port imem_wdata, output, 32: instruction word to write.
REQ-012 SHALL have port core_rst_n, output, 1: active-low reset to the pipelined core.
REQ-013 SHALL have port done, output, 1: program loaded and core running.
REQ-014 SHALL have port err, output, 1: invalid word count received.
REQ-015 SHALL have port loaded_words, output, 16: number of words written in the current load.

Function
REQ-016 SHALL implement the FSM states CNT_LO, CNT_HI, CHECK, DATA, RELEASE, RUN and ERR.
REQ-017 SHALL drive in_ready combinationally from state: 1 in CNT_LO, CNT_HI and DATA; 0 in all other states.
REQ-018 SHALL treat the stream format as a 16-bit little-endian word count N, followed by N words of 4 bytes each, little-endian (first byte is bits 7:0).
REQ-019 In CNT_LO, on a transfer, SHALL latch N[7:0] and move to CNT_HI.
REQ-020 In CNT_HI, on a transfer, SHALL latch N[15:8] and move to CHECK.
REQ-021 CHECK SHALL last exactly one cycle, moving to ERR if N==0 or N>DEPTH, otherwise to DATA with word index 0 and byte index 0.
REQ-022 In DATA, each transfer SHALL place the byte at byte index b (0..3) into assembly bits 8b+7:8b and then increment b, wrapping 3->0.
REQ-023 On the transfer of byte 3, the next cycle SHALL assert imem_we=1 for exactly one cycle, with imem_waddr = word index and imem_wdata = the assembled word.
REQ-024 SHALL keep imem_waddr and imem_wdata stable while imem_we=1.
REQ-025 SHALL increment the word index and loaded_words by 1 in the cycle imem_we asserts.
REQ-026 SHALL keep in_ready=1 during a write cycle, so the next word's byte 0 is accepted without a bubble; the output write registers are separate from the assembly register.
REQ-027 When the write of word N-1 issues, SHALL move to RELEASE; no further bytes are accepted and extra input is left unconsumed.
REQ-028 SHALL hold RELEASE for exactly 4 cycles with core_rst_n=0, then move to RUN.
REQ-029 In RUN, SHALL drive core_rst_n=1 and done=1.
REQ-030 In ERR, SHALL drive err=1 and core_rst_n=0, with no writes; the only exits are boot_req and rst.
REQ-031 In RUN or ERR, boot_req=1 SHALL move to CNT_LO and, in the following cycle, drive core_rst_n=0, done=0, err=0 and loaded_words=0.
REQ-032 SHALL ignore boot_req in CNT_LO, CNT_HI, CHECK, DATA and RELEASE.
REQ-033 SHALL register core_rst_n, done and err; they are glitch-free.
REQ-034 In every state other than RUN, core_rst_n SHALL be 0.
REQ-035 SHALL size the word index to 16 bits internally and truncate imem_waddr to its AW LSBs; N<=DEPTH guarantees no wrap.

Reset
REQ-036 With rst=1 at a clock edge, SHALL enter CNT_LO and set imem_we=0, imem_waddr=0, imem_wdata=0, core_rst_n=0, done=0, err=0, loaded_words=0, and clear the byte index, word index and N; in_ready=1 in the following cycle.
REQ-037 SHALL let rst override all other inputs, including a simultaneous transfer or boot_req.
REQ-038 Reset during DATA SHALL abort the load with no further imem writes; the next stream is parsed from a fresh count.

Verification
REQ-039 Bytes 02 00 | 13 00 00 00 | 93 00 10 00, in_valid held high -> imem_we pulses at addr 0 data 0x00000013 and at addr 1 data 0x00100093, no idle cycle between the words; core_rst_n rises 5 cycles after the second write; done=1; loaded_words=2.
REQ-040 Count bytes 00 00 -> err=1 one cycle after CHECK, in_ready=0, core_rst_n=0, no imem_we; then boot_req pulse -> err=0 and in_ready=1.
REQ-041 Count bytes 41 00 (65 > DEPTH=64) -> ERR; count 40 00 (64) -> all 64 words written, the last at addr 63.
REQ-042 in_valid toggling randomly with 1-3 cycle gaps for N=3 -> identical imem contents and write order as the gap-free run; in_ready never drops inside DATA.
REQ-043 rst asserted after byte 2 of word 1 during a load, then a new stream 01 00 EF BE AD DE -> single write of 0xDEADBEEF at addr 0, with no stale partial word.
REQ-044 boot_req asserted during DATA -> ignored and the load completes; boot_req in RUN -> core_rst_n=0 the next cycle and a new load is accepted.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// Serial boot loader: parses a word-count header plus little-endian 32-bit words,
// writes them to instruction memory, then releases the core from reset.
module boot_loader_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          boot_req,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst_n,
  output logic          done,
  output logic          err,
  output logic [15:0]   loaded_words
);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_CHECK,
    S_DATA,
    S_RELEASE,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   widx_q, widx_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [31:0]   asm_q, asm_d;
  logic [1:0]    rel_q, rel_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   loaded_q, loaded_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          xfer;

  assign in_ready = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                    (state_q == S_DATA);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    bidx_d   = bidx_q;
    asm_d    = asm_q;
    rel_d    = rel_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    loaded_d = loaded_q;
    case (state_q)
      S_CNT_LO: begin
        if (xfer) begin
          cnt_d[7:0] = in_data;
          state_d    = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          cnt_d[15:8] = in_data;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cnt_q == 16'd0 || cnt_q > 16'(DEPTH)) begin
          state_d = S_ERR;
        end else begin
          state_d = S_DATA;
          widx_d  = 16'd0;
          bidx_d  = 2'd0;
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d[{bidx_q, 3'b000} +: 8] = in_data;
          bidx_d = bidx_q + 2'd1;
          // Output write registers are loaded straight from the incoming byte,
          // so the assembly register is free for the next word immediately.
          if (bidx_q == 2'd3) begin
            we_d     = 1'b1;
            waddr_d  = widx_q[AW-1:0];
            wdata_d  = {in_data, asm_q[23:0]};
            widx_d   = widx_q + 16'd1;
            loaded_d = loaded_q + 16'd1;
            if (widx_q == cnt_q - 16'd1) begin
              state_d = S_RELEASE;
              rel_d   = 2'd0;
            end
          end
        end
      end
      S_RELEASE: begin
        rel_d = rel_q + 2'd1;
        if (rel_q == 2'd3) state_d = S_RUN;
      end
      S_RUN, S_ERR: begin
        if (boot_req) begin
          state_d  = S_CNT_LO;
          cnt_d    = 16'd0;
          widx_d   = 16'd0;
          bidx_d   = 2'd0;
          loaded_d = 16'd0;
        end
      end
      default: state_d = S_CNT_LO;
    endcase
  end

  // Core reset/done follow the registered RUN state, and drop the cycle after boot_req.
  always_comb begin
    core_rst_n_d = (state_q == S_RUN) && !boot_req;
    done_d       = (state_q == S_RUN) && !boot_req;
    err_d        = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CNT_LO;
      cnt_q        <= 16'd0;
      widx_q       <= 16'd0;
      bidx_q       <= 2'd0;
      asm_q        <= 32'd0;
      rel_q        <= 2'd0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= 32'd0;
      loaded_q     <= 16'd0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      asm_q        <= asm_d;
      rel_q        <= rel_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      loaded_q     <= loaded_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign core_rst_n   = core_rst_n_q;
  assign done         = done_q;
  assign err          = err_q;
  assign loaded_words = loaded_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed + randomized bench for boot_loader_ctrl against a stream-level model.
module tb_boot_loader_ctrl;
  typedef logic [7:0] byte_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, boot_req;
  logic [7:0]  in_data;
  logic        imem_we, core_rst_n, done, err;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [15:0] loaded_words;

  int errors = 0, checks = 0, cyc = 0;
  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  byte_t       stim[$];

  boot_loader_ctrl #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .boot_req(boot_req), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
    .done(done), .err(err), .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa_q.push_back(imem_waddr);
      wd_q.push_back(imem_wdata);
      wc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; boot_req = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic build(input int n, input int words);
    stim.delete();
    stim.push_back(byte_t'(n & 8'hff));
    stim.push_back(byte_t'((n >> 8) & 8'hff));
    for (int i = 0; i < 4 * words; i++) stim.push_back(byte_t'($urandom_range(255, 0)));
  endtask

  // Offers stim bytes in order; maxgap>0 inserts random idle cycles between bytes.
  task automatic send(input int maxgap, input int boot_at);
    int i = 0, gap = 0, guard = 0, drops = 0;
    while (i < stim.size() && guard < 3000) begin
      @(negedge clk);
      guard++;
      boot_req = (boot_at >= 0 && i == boot_at);
      if (i >= 3 && in_ready !== 1'b1) drops++;
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        in_data  = stim[i];
        if (in_ready === 1'b1) begin
          i++;
          if (maxgap > 0 && $urandom_range(1, 0) == 1) gap = $urandom_range(maxgap, 1);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; boot_req = 1'b0;
    if (guard >= 3000) chk("send_timeout", guard, 0);
    if (stim.size() > 3) chk("in_ready_drops_in_data", drops, 0);
  endtask

  task automatic wait_done();
    int g = 0;
    while (done !== 1'b1 && g < 400) begin @(negedge clk); g++; end
    if (g >= 400) chk("done_timeout", done, 1);
  endtask

  // Expected writes derived purely from the byte stream.
  task automatic check_writes(input string tag);
    int n, nexp;
    logic [31:0] w;
    n = int'(stim[0]) | (int'(stim[1]) << 8);
    nexp = (n == 0 || n > 64) ? 0 : n;
    chk({tag, "_wr_count"}, wd_q.size(), nexp);
    for (int i = 0; i < nexp && i < wd_q.size(); i++) begin
      w = {stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]};
      chk({tag, "_addr"}, wa_q[i], i);
      chk({tag, "_data"}, wd_q[i], w);
    end
  endtask

  task automatic pulse_boot();
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  initial begin
    int g;
    byte_t saved[$];
    rst = 1'b1; in_valid = 1'b0; boot_req = 1'b0; in_data = 8'h00;
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_core_rst_n", core_rst_n, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_loaded", loaded_words, 0);

    // Two-word directed load, then extra input that must stay unconsumed.
    clear_log();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send(0, -1);
    in_valid = 1'b1; in_data = 8'hAA;
    g = 0;
    while (core_rst_n !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    chk("d2_core_rst_timeout", (g < 50), 1);
    check_writes("d2");
    if (wc_q.size() == 2) begin
      chk("d2_word_spacing", wc_q[1] - wc_q[0], 4);
      chk("d2_release_delay", cyc - wc_q[1], 5);
    end
    chk("d2_done", done, 1);
    chk("d2_loaded", loaded_words, 2);
    chk("d2_in_ready_run", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("d2_no_extra_write", wd_q.size(), 2);
    in_valid = 1'b0;

    // boot_req in RUN restarts the loader.
    pulse_boot();
    chk("br_core_rst_n", core_rst_n, 0);
    chk("br_done", done, 0);
    chk("br_loaded", loaded_words, 0);
    chk("br_in_ready", in_ready, 1);

    // Zero count -> ERR.
    clear_log();
    stim = '{8'h00, 8'h00};
    send(0, -1);
    chk("z_err_check_cycle", err, 0);
    @(negedge clk);
    chk("z_err", err, 1);
    chk("z_in_ready", in_ready, 0);
    chk("z_core_rst_n", core_rst_n, 0);
    repeat (3) @(negedge clk);
    chk("z_err_held", err, 1);
    check_writes("z");
    pulse_boot();
    chk("z_err_clear", err, 0);
    chk("z_in_ready_back", in_ready, 1);

    // Count 65 exceeds DEPTH.
    clear_log();
    stim = '{8'h41, 8'h00};
    send(0, -1);
    repeat (2) @(negedge clk);
    chk("ovf_err", err, 1);
    check_writes("ovf");
    pulse_boot();

    // Full-depth load of 64 random words.
    clear_log();
    build(64, 64);
    send(0, -1);
    wait_done();
    check_writes("full");
    if (wa_q.size() == 64) chk("full_last_addr", wa_q[63], 63);
    chk("full_loaded", loaded_words, 64);
    pulse_boot();

    // N=3, gap-free reference then the same bytes with random gaps.
    build(3, 3);
    saved = stim;
    clear_log();
    send(0, -1);
    wait_done();
    check_writes("n3_nogap");
    pulse_boot();
    for (int r = 0; r < 4; r++) begin
      stim = saved;
      clear_log();
      send(3, -1);
      wait_done();
      check_writes("n3_gap");
      pulse_boot();
    end

    // boot_req during DATA is ignored.
    clear_log();
    build(2, 2);
    send(1, 5);
    wait_done();
    check_writes("bdata");
    chk("bdata_loaded", loaded_words, 2);
    pulse_boot();

    // Reset mid-word aborts; fresh stream parses from a new count.
    clear_log();
    build(2, 2);
    stim = stim[0:8];
    send(0, -1);
    chk("abort_word0_written", wd_q.size(), 1);
    do_reset();
    chk("abort_rst_loaded", loaded_words, 0);
    clear_log();
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send(0, -1);
    wait_done();
    check_writes("fresh");
    if (wd_q.size() == 1) chk("fresh_deadbeef", wd_q[0], 32'hDEADBEEF);

    // Random counts including invalid ones.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(70, 0);
      pulse_boot();
      do_reset();
      clear_log();
      build(n, (n > 64) ? 0 : n);
      send($urandom_range(2, 0), -1);
      if (n == 0 || n > 64) begin
        repeat (2) @(negedge clk);
        chk("rnd_err", err, 1);
      end else begin
        wait_done();
        chk("rnd_loaded", loaded_words, n);
      end
      check_writes("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
